// File: rtl/noc_injection_arbiter.sv
// NoC injection arbiter. Several AXI4-Stream requesters share a single NoC
// injection port. A round-robin pick is made in IDLE, and the chosen port then
// owns the output until its packet ends. A packet ends on tlast, or it is cut
// short when MAX_FLITS flits have been sent.
//
// Handshake: a flit moves on a rising edge where valid and ready are both 1.
// A source holds its valid and payload until that edge. This block raises
// ready only toward the granted source, and only by passing m_tready_i
// through to it.
module noc_injection_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 64,
  parameter int DEST_WIDTH = 8,
  parameter int MAX_FLITS  = 16
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic [NUM_PORTS-1:0]                              s_tvalid_i,
  output logic [NUM_PORTS-1:0]                              s_tready_o,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]                   s_tdata_i,
  input  logic [NUM_PORTS*DEST_WIDTH-1:0]                   s_tdest_i,
  input  logic [NUM_PORTS-1:0]                              s_tlast_i,
  output logic                                              m_tvalid_o,
  input  logic                                              m_tready_i,
  output logic [DATA_WIDTH-1:0]                             m_tdata_o,
  output logic [DEST_WIDTH-1:0]                             m_tdest_o,
  output logic                                              m_tlast_o,
  output logic [((NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1)-1:0] m_tid_o,
  output logic [NUM_PORTS-1:0]                              grant_o,
  output logic                                              overrun_err_o
);

  localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int CNT_W = $clog2(MAX_FLITS);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             overrun_q, overrun_d;

  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic             sel_valid;
  logic             sel_last;
  logic             at_cap;
  logic             hs;

  // Round-robin pick. The scan starts at the port after the last winner. It
  // runs backwards so that the candidate nearest to ptr+1 writes last and wins.
  always_comb begin : rr_pick
    int               idx;
    logic [IDX_W-1:0] idx_b;
    idx      = 0;
    idx_b    = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      idx   = (int'(ptr_q) + 1 + i) % NUM_PORTS;
      idx_b = IDX_W'(idx);
      if (s_tvalid_i[idx_b]) begin
        pick     = idx_b;
        pick_vld = 1'b1;
      end
    end
  end

  // Pass the granted port straight through to the output. The outputs are
  // quiet whenever no packet is locked.
  always_comb begin
    sel_valid     = s_tvalid_i[grant_q];
    sel_last      = s_tlast_i[grant_q];
    at_cap        = (cnt_q == CNT_W'(MAX_FLITS - 1));
    s_tready_o    = '0;
    grant_o       = '0;
    m_tvalid_o    = 1'b0;
    m_tdata_o     = '0;
    m_tdest_o     = '0;
    m_tlast_o     = 1'b0;
    m_tid_o       = '0;
    overrun_err_o = overrun_q;
    if (state_q == LOCKED) begin
      m_tvalid_o          = sel_valid;
      s_tready_o[grant_q] = m_tready_i;
      grant_o[grant_q]    = 1'b1;
      m_tdata_o           = s_tdata_i[grant_q*DATA_WIDTH +: DATA_WIDTH];
      m_tdest_o           = s_tdest_i[grant_q*DEST_WIDTH +: DEST_WIDTH];
      m_tlast_o           = sel_last | at_cap;
      m_tid_o             = grant_q;
    end
    hs = m_tvalid_o & m_tready_i;
  end

  // Next-state logic: arbitrate in IDLE, count flits while LOCKED, and release
  // the grant on the last flit. A flit counted as last without tlast from the
  // source is a forced cut, and it sets the sticky overrun flag.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          cnt_d   = '0;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (hs) begin
          if (m_tlast_o) begin
            state_d = IDLE;
            ptr_d   = grant_q;
            cnt_d   = '0;
            if (!sel_last) begin
              overrun_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. After reset the pointer sits on the last port, so port 0
  // is checked first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      ptr_q     <= IDX_W'(NUM_PORTS - 1);
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_noc_injection_arbiter.sv
// Bench for noc_injection_arbiter at its default parameters. Each port has a
// source model: a queue of flits that drives valid/payload and pops an entry
// on a handshake. Expected output flits go to exp_q in the order they should
// leave the arbiter.
module tb_noc_injection_arbiter;

  localparam int NP  = 4;
  localparam int DW  = 64;
  localparam int DSW = 8;
  localparam int MF  = 16;
  localparam int EW  = 2 + 1 + DSW + DW;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     s_tvalid_i;
  logic [NP-1:0]     s_tready_o;
  logic [NP*DW-1:0]  s_tdata_i;
  logic [NP*DSW-1:0] s_tdest_i;
  logic [NP-1:0]     s_tlast_i;
  logic              m_tvalid_o;
  logic              m_tready_i;
  logic [DW-1:0]     m_tdata_o;
  logic [DSW-1:0]    m_tdest_o;
  logic              m_tlast_o;
  logic [1:0]        m_tid_o;
  logic [NP-1:0]     grant_o;
  logic              overrun_err_o;

  noc_injection_arbiter #(
    .NUM_PORTS(NP), .DATA_WIDTH(DW), .DEST_WIDTH(DSW), .MAX_FLITS(MF)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o), .s_tdata_i(s_tdata_i),
    .s_tdest_i(s_tdest_i), .s_tlast_i(s_tlast_i),
    .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i), .m_tdata_o(m_tdata_o),
    .m_tdest_o(m_tdest_o), .m_tlast_o(m_tlast_o), .m_tid_o(m_tid_o),
    .grant_o(grant_o), .overrun_err_o(overrun_err_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  // ---------------- bench state ----------------
  logic [EW-1:0] exp_q[$];
  logic [72:0]   src_q[NP][$];
  int            hs_cyc[$];
  logic          ovr_q[$];
  logic [NP-1:0] src_hs;
  int            cyc = 0;
  int            rx_cnt = 0;
  int            n_tests = 0;
  int            n_fail = 0;
  logic          stall_chk = 1'b0;
  logic [DW-1:0] stall_data;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_sources();
    logic [72:0] f;
    for (int k = 0; k < NP; k++) begin
      if (src_q[k].size() > 0) begin
        f = src_q[k][0];
        s_tvalid_i[k]             = 1'b1;
        s_tlast_i[k]              = f[72];
        s_tdest_i[k*DSW +: DSW]   = f[71:64];
        s_tdata_i[k*DW +: DW]     = f[63:0];
      end else begin
        s_tvalid_i[k] = 1'b0;
        s_tlast_i[k]  = 1'b0;
      end
    end
  endtask

  // Queue a packet at a source and push its expected output flits. A flit is
  // expected to show tlast if the source marks it, or if it is the MF-th flit
  // of a run with no tlast.
  task automatic queue_pkt(input int port, input int n, input bit with_last);
    logic [DW-1:0]  d;
    logic [DSW-1:0] ds;
    logic           sl, el;
    for (int i = 0; i < n; i++) begin
      d  = {$urandom, $urandom};
      ds = DSW'($urandom_range(0, 255));
      sl = with_last && (i == n - 1);
      el = sl || ((i % MF) == MF - 1);
      src_q[port].push_back({sl, ds, d});
      exp_q.push_back({2'(port), el, ds, d});
    end
  endtask

  task automatic flush_all();
    exp_q.delete();
    for (int k = 0; k < NP; k++) src_q[k].delete();
    hs_cyc.delete();
    ovr_q.delete();
  endtask

  // One clock: the monitor samples at the falling edge, then the sources
  // advance just after the rising edge.
  task automatic step();
    logic [EW-1:0] e;
    @(negedge clk_i);
    src_hs = s_tvalid_i & s_tready_o;
    if (stall_chk) begin
      check_eq("stall_valid", m_tvalid_o, 1'b1);
      check_eq("stall_sready", s_tready_o, '0);
      check_eq("stall_data", m_tdata_o, stall_data);
    end
    if (m_tvalid_o && m_tready_i) begin
      rx_cnt++;
      hs_cyc.push_back(cyc);
      ovr_q.push_back(overrun_err_o);
      if (exp_q.size() == 0) begin
        check_eq("sb_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("flit", {m_tid_o, m_tlast_o, m_tdest_o, m_tdata_o}, e);
        check_eq("grant_onehot", grant_o, 4'b0001 << e[EW-1:EW-2]);
        check_eq("sready_granted", s_tready_o, 4'b0001 << e[EW-1:EW-2]);
      end
    end
    @(posedge clk_i);
    cyc++;
    #1;
    if (!rst_i) begin
      for (int k = 0; k < NP; k++)
        if (src_hs[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
    end
    drive_sources();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq(tag, exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, grant_o, '0);
    check_eq({tag, "_sready"}, s_tready_o, '0);
    check_eq({tag, "_mvalid"}, m_tvalid_o, 1'b0);
    check_eq({tag, "_mlast"}, m_tlast_o, 1'b0);
    check_eq({tag, "_tid"}, m_tid_o, '0);
    check_eq({tag, "_ovr"}, overrun_err_o, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  initial begin : main
    int base, rx0, n;
    int b_rel[6];
    b_rel = '{1, 2, 3, 5, 6, 7};
    rst_i = 1'b1; m_tready_i = 1'b1;
    s_tvalid_i = '0; s_tdata_i = '0; s_tdest_i = '0; s_tlast_i = '0;

    // Reset with every source requesting, then 1-flit packets in strict rotation.
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) queue_pkt(p, 1, 1'b1);
    drive_sources();
    #1;
    check_reset_outputs("rst_init");
    repeat (3) step();
    check_reset_outputs("rst_hold");
    rst_i = 1'b0;
    wait_drain("rr_drain", 40);
    check_eq("rr_count", hs_cyc.size(), 8);
    for (int i = 1; i < hs_cyc.size(); i++) check_eq("rr_gap", hs_cyc[i] - hs_cyc[i-1], 2);

    // Ports 0 and 2 with 3-flit packets: flits at cycles 1-3, a bubble, then 5-7.
    step(); step();
    flush_all();
    base = cyc;
    queue_pkt(0, 3, 1'b1);
    queue_pkt(2, 3, 1'b1);
    drive_sources();
    wait_drain("two_drain", 30);
    check_eq("two_count", hs_cyc.size(), 6);
    for (int i = 0; i < 6 && i < hs_cyc.size(); i++) check_eq("two_cycle", hs_cyc[i] - base, b_rel[i]);

    // Port 3 with a 4-flit packet, stalled for 5 cycles while flit 2 is presented.
    step();
    flush_all();
    queue_pkt(3, 4, 1'b1);
    drive_sources();
    rx0 = rx_cnt; n = 0;
    while (rx_cnt < rx0 + 1 && n < 20) begin step(); n++; end
    check_eq("stall_first", rx_cnt - rx0, 1);
    m_tready_i = 1'b0;
    stall_data = exp_q[0][DW-1:0];
    stall_chk = 1'b1;
    repeat (5) step();
    stall_chk = 1'b0;
    check_eq("stall_no_flit", rx_cnt - rx0, 1);
    m_tready_i = 1'b1;
    wait_drain("stall_drain", 20);
    check_eq("stall_count", rx_cnt - rx0, 4);

    // Port 1 sends 20 flits without tlast: cut at flit 16, overrun, re-arbitrated tail.
    step();
    flush_all();
    queue_pkt(1, 20, 1'b0);
    drive_sources();
    check_eq("ovr_before", overrun_err_o, 1'b0);
    wait_drain("ovr_drain", 60);
    check_eq("ovr_count", hs_cyc.size(), 20);
    for (int i = 1; i < hs_cyc.size(); i++)
      check_eq("ovr_gap", hs_cyc[i] - hs_cyc[i-1], (i == 16) ? 2 : 1);
    for (int i = 0; i < ovr_q.size(); i++) check_eq("ovr_flag", ovr_q[i], (i >= 16) ? 1'b1 : 1'b0);
    repeat (3) step();
    check_eq("ovr_sticky", overrun_err_o, 1'b1);

    // Reset during operation clears the sticky flag and every output.
    rst_i = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    flush_all();
    step();
    rst_i = 1'b0;

    // Port 2 has a 5-flit packet and reset hits during flit 2. Port 0 then wins first.
    queue_pkt(2, 5, 1'b1);
    drive_sources();
    rx0 = rx_cnt; n = 0;
    while (rx_cnt < rx0 + 1 && n < 20) begin step(); n++; end
    check_eq("abort_first", rx_cnt - rx0, 1);
    check_eq("abort_pre_valid", m_tvalid_o, 1'b1);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("abort_mvalid", m_tvalid_o, 1'b0);
    check_eq("abort_grant", grant_o, '0);
    flush_all();
    queue_pkt(0, 1, 1'b1);
    queue_pkt(3, 2, 1'b1);
    drive_sources();
    repeat (2) step();
    check_eq("abort_quiet", hs_cyc.size(), 0);
    rst_i = 1'b0;
    wait_drain("abort_drain", 20);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
